// File: rtl/arm_pkg.sv
// Shared types and constants for the ARM pipeline hazard unit.
package arm_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ERR
    } memfsm_t;

    localparam logic [3:0] PC_REG = 4'd15;

endpackage

// File: rtl/arm_fwd_sel.sv
// Forwarding select for one E-stage source operand: M result beats W result.
module arm_fwd_sel
    import arm_pkg::*;
#(
    parameter int unsigned RA_W = 4
) (
    input  logic [RA_W-1:0] ra_e,
    input  logic [RA_W-1:0] wa_m,
    input  logic [RA_W-1:0] wa_w,
    input  logic            reg_write_m,
    input  logic            reg_write_w,
    output fwd_sel_t        sel
);

    // R15 reads come from the PC+8 path and are never forwarded
    always_comb begin
        sel = FWD_RF;
        if (ra_e != RA_W'(PC_REG)) begin
            if (reg_write_m && (wa_m == ra_e)) begin
                sel = FWD_M;
            end else if (reg_write_w && (wa_w == ra_e)) begin
                sel = FWD_W;
            end
        end
    end

endmodule

// File: rtl/arm_hazard_unit.sv
// Hazard/forwarding controller for the 5-stage pipe: forwarding, load-use and
// PC-write stalls, branch flushes, dmem wait freeze, perf counters and timeout flag.
module arm_hazard_unit
    import arm_pkg::*;
#(
    parameter int unsigned RA_W    = 4,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [RA_W-1:0]  RA1D,
    input  logic [RA_W-1:0]  RA2D,
    input  logic [RA_W-1:0]  RA1E,
    input  logic [RA_W-1:0]  RA2E,
    input  logic [RA_W-1:0]  WA3E,
    input  logic [RA_W-1:0]  WA3M,
    input  logic [RA_W-1:0]  WA3W,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             PCWrPendingF,
    input  logic             BranchTakenE,
    input  logic             dmem_req_M,
    input  logic             dmem_ready,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned WC_W = $clog2(TIMEOUT + 1);

    memfsm_t         state;
    logic [WC_W-1:0] wcnt;
    fwd_sel_t        fwd_a;
    fwd_sel_t        fwd_b;
    logic            memwait;
    logic            ldr_stall;

    arm_fwd_sel #(.RA_W(RA_W)) u_fwd_a (
        .ra_e(RA1E), .wa_m(WA3M), .wa_w(WA3W),
        .reg_write_m(RegWriteM), .reg_write_w(RegWriteW), .sel(fwd_a)
    );

    arm_fwd_sel #(.RA_W(RA_W)) u_fwd_b (
        .ra_e(RA2E), .wa_m(WA3M), .wa_w(WA3W),
        .reg_write_m(RegWriteM), .reg_write_w(RegWriteW), .sel(fwd_b)
    );

    assign ForwardAE = reset ? fwd_a : FWD_RF;
    assign ForwardBE = reset ? fwd_b : FWD_RF;

    assign ldr_stall = MemtoRegE && ((WA3E == RA1D) || (WA3E == RA2D));
    assign memwait   = reset && dmem_req_M && !dmem_ready && (state != ERR);

    // Memory wait tracker; a withdrawn request also ends the wait
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            wcnt        <= '0;
            mem_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (dmem_req_M && !dmem_ready) begin
                        state <= WAIT;
                        wcnt  <= WC_W'(1);
                    end
                end
                WAIT: begin
                    if (!dmem_req_M || dmem_ready) begin
                        state <= IDLE;
                    end else if (wcnt == WC_W'(TIMEOUT)) begin
                        state       <= ERR;
                        mem_timeout <= 1'b1;
                    end else begin
                        wcnt <= wcnt + WC_W'(1);
                    end
                end
                ERR: begin
                    if (!dmem_req_M) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stall/flush priority: memory freeze overrides branch and load-use handling
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (!reset) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushW = 1'b1;
        end else if (memwait) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else begin
            StallF = ldr_stall || PCWrPendingF;
            StallD = ldr_stall;
            FlushD = PCWrPendingF || BranchTakenE;
            FlushE = ldr_stall || BranchTakenE;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (StallF && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (FlushE && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule
